// File: rtl/expr_emitter.sv
// Serialises a captured arithmetic expression (digit (op digit)*) into an
// ASCII character stream with a valid/ready handshake.
module expr_emitter #(
    parameter int MAX_TERMS = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [3:0]             count,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic [7:0]             out_char,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, DIG, OP, DONE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_TERMS);
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_STAR = 8'h2A;

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             count_q, count_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [MAX_TERMS-2:0]   ops_q, ops_d;
    logic [7:0]             char_q, char_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic                   term_bad;
    logic                   legal;
    logic [63:0]            digits_ext;
    logic [15:0]            ops_ext;
    logic [3:0]             cur_term;
    logic [3:0]             next_term;
    logic                   cur_op;
    logic                   last_term;
    logic                   transfer;

    // Only terms below the requested count take part in the legality check.
    always_comb begin
        term_bad = 1'b0;
        for (int k = 0; k < MAX_TERMS; k++) begin
            if ((4'(k) < count) && (digits[4*k +: 4] > 4'd9)) begin
                term_bad = 1'b1;
            end
        end
        legal = (count != 4'd0) && (count <= MAX_CNT) && !term_bad;
    end

    always_comb begin
        digits_ext = 64'(digits_q);
        ops_ext    = 16'(ops_q);
        cur_term   = digits_ext[{idx_q, 2'b00} +: 4];
        next_term  = digits_ext[{idx_q + 4'd1, 2'b00} +: 4];
        cur_op     = ops_ext[idx_q];
        last_term  = (idx_q == count_q - 4'd1);
        transfer   = valid_q & out_ready;
    end

    // Next character is prepared at the edge that changes state, so the
    // outputs come straight from registers and never see out_ready.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        char_d   = char_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        count_d  = count;
                        digits_d = digits;
                        ops_d    = ops;
                        idx_d    = 4'd0;
                        char_d   = ASCII_0 + {4'h0, digits[3:0]};
                        valid_d  = 1'b1;
                        state_d  = DIG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIG: begin
                if (transfer) begin
                    if (last_term) begin
                        char_d  = 8'h00;
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        char_d  = cur_op ? ASCII_STAR : ASCII_PLUS;
                        state_d = OP;
                    end
                end
            end
            OP: begin
                if (transfer) begin
                    idx_d   = idx_q + 4'd1;
                    char_d  = ASCII_0 + {4'h0, next_term};
                    state_d = DIG;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                char_d  = 8'h00;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            count_q  <= 4'd0;
            digits_q <= '0;
            ops_q    <= '0;
            char_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign out_char  = char_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_expr_emitter.sv
// Scoreboard bench for expr_emitter: the driver queues hand-written expected
// strings, a negedge monitor pops them on every transfer.
module tb_expr_emitter;

    localparam int MAX_TERMS = 8;

    logic                   clk = 1'b0;
    logic                   clr;
    logic                   start;
    logic [3:0]             count;
    logic [4*MAX_TERMS-1:0] digits;
    logic [MAX_TERMS-2:0]   ops;
    logic [7:0]             out_char;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;
    logic                   err;

    byte expQ[$];
    byte expCh;
    int  checks = 0;
    int  failures = 0;
    int  doneSeen = 0;
    int  doneExp = 0;
    int  errSeen = 0;
    int  errExp = 0;

    // Loopback model of the expression checker.
    bit  chkExpectDigit = 1'b1;
    bit  chkValid = 1'b0;
    bit  chkError = 1'b0;

    expr_emitter #(.MAX_TERMS(MAX_TERMS)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .count     (count),
        .digits    (digits),
        .ops       (ops),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: sampled on the falling edge, a transfer is pending for the
    // coming rising edge when valid & ready hold and clr is not asserted.
    always @(negedge clk) begin
        if (clr) begin
            chkExpectDigit = 1'b1;
            chkValid = 1'b0;
            chkError = 1'b0;
        end else begin
            if (!out_valid) checkOutput("idleCharZero", {24'h0, out_char}, 32'h0);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spuriousChar: got %0h, expected no character", out_char);
                end else begin
                    expCh = expQ.pop_front();
                    checkOutput("streamChar", {24'h0, out_char}, {24'h0, expCh});
                end
                if (chkExpectDigit && out_char >= 8'h30 && out_char <= 8'h39) begin
                    chkValid = 1'b1;
                    chkExpectDigit = 1'b0;
                    checkOutput("loopValidAfterDigit", {31'h0, chkValid}, 32'h1);
                end else if (!chkExpectDigit && (out_char == 8'h2B || out_char == 8'h2A)) begin
                    chkValid = 1'b0;
                    chkExpectDigit = 1'b1;
                end else begin
                    chkError = 1'b1;
                end
                checkOutput("loopNoError", {31'h0, chkError}, 32'h0);
            end
            if (done) begin
                doneSeen++;
                checkOutput("loopValidAtDone", {31'h0, chkValid}, 32'h1);
                chkExpectDigit = 1'b1;
                chkValid = 1'b0;
                chkError = 1'b0;
            end
            if (err) errSeen++;
        end
    end

    // Issues one start at posedge+1; an empty expected string means rejection.
    task automatic applyStimulus(input logic [3:0] cnt, input logic [31:0] digs,
                                 input logic [6:0] o, input string expStr);
        for (int i = 0; i < expStr.len(); i++) expQ.push_back(expStr[i]);
        count  = cnt;
        digits = digs;
        ops    = o;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expStr.len() > 0) begin
            doneExp++;
            checkOutput("firstValid", {31'h0, out_valid}, 32'h1);
            checkOutput("firstChar", {24'h0, out_char}, {24'h0, expStr[0]});
            checkOutput("busyAfterStart", {31'h0, busy}, 32'h1);
        end else begin
            errExp++;
            checkOutput("errPulse", {31'h0, err}, 32'h1);
            checkOutput("errNoValid", {31'h0, out_valid}, 32'h0);
            checkOutput("errNotBusy", {31'h0, busy}, 32'h0);
            @(posedge clk);
            #1;
            checkOutput("errOneCycle", {31'h0, err}, 32'h0);
            checkOutput("errStillNoValid", {31'h0, out_valid}, 32'h0);
        end
    endtask

    // Waits (bounded) for done, then confirms the stream drained and busy drops.
    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_doneSeen"}, {31'h0, seen}, 32'h1);
        checkOutput({name, "_queueDrained"}, expQ.size(), 32'h0);
        expQ.delete();
        @(negedge clk);
        checkOutput({name, "_busyLow"}, {31'h0, busy}, 32'h0);
        checkOutput({name, "_donePulse"}, {31'h0, done}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        count = 4'd0;
        digits = '0;
        ops = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstChar", {24'h0, out_char}, 32'h0);
        checkOutput("rstValid", {31'h0, out_valid}, 32'h0);
        checkOutput("rstBusy", {31'h0, busy}, 32'h0);
        checkOutput("rstDone", {31'h0, done}, 32'h0);
        checkOutput("rstErr", {31'h0, err}, 32'h0);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Basic stream with don't-care upper terms and ops.
        applyStimulus(4'd3, 32'hFFFFF321, 7'b1111110, "1+2*3");
        waitDone("basic");

        // Backpressure: '+' held for three cycles with out_ready low.
        applyStimulus(4'd3, 32'h00000321, 7'b0000010, "1+2*3");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bpPlusShown", {24'h0, out_char}, 32'h2B);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bpHoldChar", {24'h0, out_char}, 32'h2B);
            checkOutput("bpHoldValid", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        waitDone("backpressure");

        // Single term and maximum length.
        applyStimulus(4'd1, 32'hAAAAAAA7, 7'h7F, "7");
        waitDone("single");
        applyStimulus(4'd8, 32'h76543210, 7'b0101010, "0+1*2+3*4+5*6+7");
        waitDone("maxlen");

        // Rejections.
        applyStimulus(4'd0, 32'h00000000, 7'h00, "");
        applyStimulus(4'd2, 32'h000000A3, 7'h00, "");
        applyStimulus(4'd9, 32'h00000000, 7'h00, "");

        // Start while busy, with inputs changed after capture.
        applyStimulus(4'd3, 32'h00000789, 7'b0000000, "9+8+7");
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 4'd2;
        digits = 32'h00000000;
        ops = 7'h7F;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("startBusy");

        // Mid-stream clear while '*' is pending, then a fresh expression.
        applyStimulus(4'd3, 32'h00000321, 7'b0000010, "1+2*3");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("clrStarPending", {24'h0, out_char}, 32'h2A);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        expQ.delete();
        doneExp--;
        checkOutput("clrChar", {24'h0, out_char}, 32'h0);
        checkOutput("clrValid", {31'h0, out_valid}, 32'h0);
        checkOutput("clrBusy", {31'h0, busy}, 32'h0);
        checkOutput("clrDone", {31'h0, done}, 32'h0);
        checkOutput("clrErr", {31'h0, err}, 32'h0);
        applyStimulus(4'd2, 32'h00000054, 7'b0000001, "4*5");
        waitDone("afterClr");

        repeat (2) @(posedge clk);
        checkOutput("doneCount", doneSeen, doneExp);
        checkOutput("errCount", errSeen, errExp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/expr_emitter.md
# expr_emitter

Transmit-side counterpart of the expression checker: serialises a loaded arithmetic expression into an 8-bit ASCII character stream, one character per accepted transfer. The stream has the form digit (op digit)*, with digits '0'–'9' and operators '+' or '*'. A checker fed this stream reports a valid expression after every digit. The block sits between a control source that supplies terms and operators, and any character-stream consumer.

## Interface
- MAX_TERMS, 8, maximum number of operand digits per expression; legal range 2..15.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  load request; sampled only in IDLE.
- count  in  4  number of terms to emit; legal range 1..MAX_TERMS.
- digits  in  4*MAX_TERMS  term k is digits[4k+3:4k] (binary 0..9); term 0 is emitted first.
- ops  in  MAX_TERMS-1  ops[k] selects the operator between term k and term k+1 (0 = '+', 1 = '*').
- out_char  out  8  current ASCII character; 8'h00 whenever out_valid = 0.
- out_valid  out  1  out_char holds a character.
- out_ready  in  1  consumer accepts; a transfer occurs on an edge where out_valid & out_ready = 1.
- busy  out  1  high in DIG, OP and DONE.
- done  out  1  one-cycle pulse after the final digit is accepted.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, DIG, OP, DONE. A term index idx (4 bits) counts from 0 to count-1.
- IDLE, start = 1, request legal:
  - capture count, digits and ops into internal registers;
  - set idx = 0 and go to DIG.
  - Input changes after capture have no effect.
- IDLE, start = 1, request illegal:
  - illegal means count = 0, count > MAX_TERMS, or any term k < count with value > 9;
  - err = 1 for exactly one cycle; stay in IDLE; emit nothing.
- DIG: out_char = 8'h30 + term[idx] ("0".."9"); out_valid = 1. On transfer:
  - if idx = count-1, go to DONE;
  - otherwise go to OP.
- OP: out_char = ops[idx] ? 8'h2A ("*") : 8'h2B ("+"); out_valid = 1. On transfer: idx = idx+1, go to DIG.
- Hold rule: while out_valid = 1 and out_ready = 0, out_char and the state stay unchanged.
- DONE: out_valid = 0; done = 1 for this single cycle; return to IDLE on the next edge.
- start is ignored while busy = 1. It is not queued.
- count = 1 produces one digit and no operator.
- Terms at index count or above, and ops bits at index count-1 or above, are don't-care.
- clr = 1 at an edge, in any state, including mid-stream with a character pending:
  - state = IDLE, idx = 0;
  - out_valid, out_char, busy, done and err all go to 0;
  - the partially sent expression is abandoned. clr takes priority over start and out_ready.

## Timing
- Reset values: out_char = 8'h00, out_valid = 0, busy = 0, done = 0, err = 0, state = IDLE.
- start is sampled at edge T. From T+1 onward, out_valid = 1 with the first digit.
- err is high during cycle T+1.
- With out_ready held at 1, one character is transferred per cycle. An expression of n terms takes 2n-1 transfer cycles.
- done is high in the cycle after the last transfer. busy drops one cycle after that.
- A new start is accepted at the earliest at the edge where the block is back in IDLE, so expressions are separated by at least 2 cycles.
- All outputs are registered, or decoded from registered state only. There is no combinational path from out_ready to out_valid or out_char.

## Test plan
- Basic stream:
  - stimulus: count = 3, terms 1,2,3, ops[0] = 0, ops[1] = 1, out_ready = 1;
  - required: out_char "1","+","2","*","3" on five consecutive cycles, then done = 1 for one cycle, then busy = 0.
- Backpressure:
  - stimulus: same load; drop out_ready for 3 cycles while "+" is presented;
  - required: "+" is held stable with out_valid = 1, the stream resumes unchanged, and the total is 5 transfers.
- Single term and max length:
  - count = 1, term 7 -> a single "7" followed by done.
  - count = 8 -> exactly 15 characters; the last is term 7.
- Rejection:
  - count = 0 -> err pulse with no out_valid.
  - count = 2 with term 1 = 4'hA -> err pulse with no out_valid.
  - start during busy -> ignored; the current stream is unaffected.
- Mid-stream reset: assert clr while "*" is pending -> next cycle all outputs are 0 and state is IDLE; a fresh start then emits correctly from term 0.
- Loopback: feed out_char into the expression checker on transfer cycles only -> the checker output is 1 after each digit and never enters its error state.
